// File: rtl/module_reg_access_decoder.sv
// Register-access decoder: edge-detects bus write/read requests and fans them out
// as registered one-hot strobes to N register slots, flagging out-of-range and colliding requests.
module module_reg_access_decoder #(
  parameter int N_REGS = 2,
  parameter int ADDR_W = 1,
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic                     rd_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic [N_REGS*DATA_W-1:0] rd_data_flat_i,
  input  logic                     err_clr_i,
  output logic [N_REGS-1:0]        wr_strb_o,
  output logic [DATA_W-1:0]        wr_data_o,
  output logic [N_REGS-1:0]        rd_strb_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  output logic                     err_o,
  output logic                     err_sticky_o
);

  logic              r_wr_q;
  logic              r_rd_q;
  logic [N_REGS-1:0] r_wr_strb;
  logic [DATA_W-1:0] r_wr_data;
  logic [N_REGS-1:0] r_rd_strb;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_err;
  logic              r_err_sticky;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_addr_ok;
  logic              w_err;
  logic [N_REGS-1:0] w_onehot;
  logic [DATA_W-1:0] w_slot;

  // An out-of-range address matches no slot, so the decode itself yields the range check.
  always_comb begin
    w_onehot = '0;
    w_slot   = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (addr_i == ADDR_W'(k)) begin
        w_onehot[k] = 1'b1;
        w_slot      = rd_data_flat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_addr_ok = |w_onehot;
  assign w_wr_acc  = wr_i & ~r_wr_q;
  assign w_rd_acc  = rd_i & ~r_rd_q;
  // A read colliding with a write is dropped and reported.
  assign w_err     = (w_wr_acc & ~w_addr_ok) | (w_rd_acc & (w_wr_acc | ~w_addr_ok));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_q       <= 1'b0;
      r_rd_q       <= 1'b0;
      r_wr_strb    <= '0;
      r_wr_data    <= '0;
      r_rd_strb    <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_wr_q     <= wr_i;
      r_rd_q     <= rd_i;
      r_wr_strb  <= '0;
      r_rd_strb  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= w_err;

      if (w_wr_acc && w_addr_ok) begin
        r_wr_strb <= w_onehot;
        r_wr_data <= data_i;
      end

      if (w_rd_acc && !w_wr_acc) begin
        r_rd_valid <= 1'b1;
        r_rd_strb  <= w_onehot;
        r_rd_data  <= w_addr_ok ? w_slot : '0;
      end

      if (w_err)
        r_err_sticky <= 1'b1;
      else if (err_clr_i)
        r_err_sticky <= 1'b0;
    end
  end

  assign wr_strb_o    = r_wr_strb;
  assign wr_data_o    = r_wr_data;
  assign rd_strb_o    = r_rd_strb;
  assign rd_data_o    = r_rd_data;
  assign rd_valid_o   = r_rd_valid;
  assign err_o        = r_err;
  assign err_sticky_o = r_err_sticky;

endmodule

// File: tb/tb_module_reg_access_decoder.sv
// Bench for module_reg_access_decoder: a 4-slot and a 3-slot instance share one stimulus
// stream and are checked every cycle against a behavioural model of the access rules.
module tb_module_reg_access_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr, rd, clr;
  logic [1:0]   addr;
  logic [31:0]  data;
  logic [31:0]  slot [4];
  logic [127:0] flat4;
  logic [95:0]  flat3;

  logic [3:0]   d4_wr_strb, d4_rd_strb;
  logic [31:0]  d4_wr_data, d4_rd_data;
  logic         d4_rd_valid, d4_err, d4_sticky;
  logic [2:0]   d3_wr_strb, d3_rd_strb;
  logic [31:0]  d3_wr_data, d3_rd_data;
  logic         d3_rd_valid, d3_err, d3_sticky;

  int n_total = 0;
  int n_pass  = 0;

  // model state, index 0 = 4-slot instance, index 1 = 3-slot instance
  int          m_n [2] = '{4, 3};
  logic        m_wq [2], m_rq [2];
  logic [3:0]  m_wstrb [2], m_rstrb [2];
  logic [31:0] m_wdata [2], m_rdata [2];
  logic        m_rvalid [2], m_err [2], m_sticky [2];

  assign flat4 = {slot[3], slot[2], slot[1], slot[0]};
  assign flat3 = {slot[2], slot[1], slot[0]};

  always #5 clk = ~clk;

  module_reg_access_decoder #(.N_REGS(4), .ADDR_W(2), .DATA_W(32)) dut4 (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .rd_i(rd), .addr_i(addr), .data_i(data),
    .rd_data_flat_i(flat4), .err_clr_i(clr),
    .wr_strb_o(d4_wr_strb), .wr_data_o(d4_wr_data), .rd_strb_o(d4_rd_strb),
    .rd_data_o(d4_rd_data), .rd_valid_o(d4_rd_valid), .err_o(d4_err), .err_sticky_o(d4_sticky)
  );

  module_reg_access_decoder #(.N_REGS(3), .ADDR_W(2), .DATA_W(32)) dut3 (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .rd_i(rd), .addr_i(addr), .data_i(data),
    .rd_data_flat_i(flat3), .err_clr_i(clr),
    .wr_strb_o(d3_wr_strb), .wr_data_o(d3_wr_data), .rd_strb_o(d3_rd_strb),
    .rd_data_o(d3_rd_data), .rd_valid_o(d3_rd_valid), .err_o(d3_err), .err_sticky_o(d3_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wq[i] = 0; m_rq[i] = 0; m_wstrb[i] = 0; m_rstrb[i] = 0;
      m_wdata[i] = 0; m_rdata[i] = 0; m_rvalid[i] = 0; m_err[i] = 0; m_sticky[i] = 0;
    end
  endtask

  // Applies the access rules for one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      bit wacc, racc, e;
      wacc = wr && !m_wq[i];
      racc = rd && !m_rq[i];
      e = 0;
      m_wstrb[i] = 0; m_rstrb[i] = 0; m_rvalid[i] = 0;
      if (wacc) begin
        if (int'(addr) < m_n[i]) begin
          m_wstrb[i] = 4'(1 << addr);
          m_wdata[i] = data;
        end else e = 1;
      end
      if (racc) begin
        if (wacc) e = 1;
        else begin
          m_rvalid[i] = 1;
          if (int'(addr) < m_n[i]) begin
            m_rdata[i] = slot[addr];
            m_rstrb[i] = 4'(1 << addr);
          end else begin
            m_rdata[i] = 0;
            e = 1;
          end
        end
      end
      m_err[i] = e;
      if (e) m_sticky[i] = 1;
      else if (clr) m_sticky[i] = 0;
      m_wq[i] = wr;
      m_rq[i] = rd;
    end
  endtask

  task automatic check_all();
    chk("d4_wr_strb",  32'(d4_wr_strb),  32'(m_wstrb[0]));
    chk("d4_wr_data",  d4_wr_data,       m_wdata[0]);
    chk("d4_rd_strb",  32'(d4_rd_strb),  32'(m_rstrb[0]));
    chk("d4_rd_data",  d4_rd_data,       m_rdata[0]);
    chk("d4_rd_valid", 32'(d4_rd_valid), 32'(m_rvalid[0]));
    chk("d4_err",      32'(d4_err),      32'(m_err[0]));
    chk("d4_sticky",   32'(d4_sticky),   32'(m_sticky[0]));
    chk("d3_wr_strb",  32'(d3_wr_strb),  32'(m_wstrb[1]));
    chk("d3_wr_data",  d3_wr_data,       m_wdata[1]);
    chk("d3_rd_strb",  32'(d3_rd_strb),  32'(m_rstrb[1]));
    chk("d3_rd_data",  d3_rd_data,       m_rdata[1]);
    chk("d3_rd_valid", 32'(d3_rd_valid), 32'(m_rvalid[1]));
    chk("d3_err",      32'(d3_err),      32'(m_err[1]));
    chk("d3_sticky",   32'(d3_sticky),   32'(m_sticky[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic reset_now();
    rst = 1;
    model_reset();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1; wr = 0; rd = 0; clr = 0; addr = 0; data = 0;
    for (int k = 0; k < 4; k++) slot[k] = 0;
    model_reset();
    step();
    step();
    chk("reset_wr_strb", 32'(d4_wr_strb), 32'd0);
    rst = 0;

    // write held high for five cycles
    wr = 1; addr = 2; data = 32'hDEADBEEF;
    step();
    chk("tp_wr_strb_once", 32'(d4_wr_strb), 32'h4);
    chk("tp_wr_data", d4_wr_data, 32'hDEADBEEF);
    for (int c = 0; c < 4; c++) step();
    chk("tp_wr_strb_held", 32'(d4_wr_strb), 32'h0);
    wr = 0;
    step();

    // read pulse at slot 1
    slot[0] = 32'h00; slot[1] = 32'h11; slot[2] = 32'h22; slot[3] = 32'h33;
    rd = 1; addr = 1;
    step();
    chk("tp_rd_data", d4_rd_data, 32'h11);
    chk("tp_rd_strb", 32'(d4_rd_strb), 32'h2);
    rd = 0;
    step();
    chk("tp_rd_valid_drop", 32'(d4_rd_valid), 32'h0);

    // out-of-range access on the 3-slot instance
    wr = 1; addr = 3; data = 32'h12345678;
    step();
    chk("tp_oor_wr_err", 32'(d3_err), 32'h1);
    wr = 0;
    step();
    chk("tp_oor_sticky", 32'(d3_sticky), 32'h1);
    rd = 1;
    step();
    chk("tp_oor_rd_data", d3_rd_data, 32'h0);
    chk("tp_oor_rd_valid", 32'(d3_rd_valid), 32'h1);
    rd = 0; clr = 1;
    step();
    chk("tp_sticky_clr", 32'(d3_sticky), 32'h0);
    clr = 0;
    step();

    // write and read rise together
    wr = 1; rd = 1; addr = 0; data = 32'hCAFE0001;
    step();
    chk("tp_collide_strb", 32'(d4_wr_strb), 32'h1);
    chk("tp_collide_err", 32'(d4_err), 32'h1);
    wr = 0; rd = 0;
    step();

    // write held across reset release, then reset while a strobe is high
    reset_now();
    wr = 1; addr = 0; data = 32'hA5A5A5A5;
    step();
    rst = 0;
    step();
    chk("tp_release_strb", 32'(d4_wr_strb), 32'h1);
    step();
    wr = 0;
    step();
    wr = 1; addr = 1; data = 32'h5A5A5A5A;
    step();
    reset_now();
    chk("tp_rst_mid_strb", 32'(d4_wr_strb), 32'h0);
    wr = 0;
    step();
    rst = 0;
    step();

    // back-to-back toggling
    wr = 1; addr = 0; data = 32'h1111AAAA;
    step();
    wr = 0;
    step();
    wr = 1; addr = 1; data = 32'h2222BBBB;
    step();
    chk("tp_toggle_strb2", 32'(d4_wr_strb), 32'h2);
    chk("tp_toggle_data2", d4_wr_data, 32'h2222BBBB);
    wr = 0;
    step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      wr   = ($urandom_range(0, 2) == 0);
      rd   = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 5) == 0);
      addr = 2'($urandom_range(0, 3));
      data = $urandom;
      for (int k = 0; k < 4; k++) slot[k] = $urandom;
      if (rst) rst = 0;
      else if ($urandom_range(0, 59) == 0) reset_now();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/module_reg_access_decoder.md
Name: module_reg_access_decoder

Overview:
- Parametrised register-access decoder between the UART bus interface and its N register slots (control, data, status, baud, ...).
- Generalises the 1-to-2 write demux to N slots with a write path, a read path, registered one-cycle strobes and request edge detection.
- Adds out-of-range address error reporting.
- Sits between the bus-side request logic and the per-register storage/FIFO blocks.

Parameters:
- N_REGS, 2, number of addressable register slots (>= 2).
- ADDR_W, 1, address width; must satisfy 2**ADDR_W >= N_REGS.
- DATA_W, 32, data width of each register.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-high reset
- wr_i  input  1  write request level; edge-detected
- rd_i  input  1  read request level; edge-detected
- addr_i  input  ADDR_W  register slot select
- data_i  input  DATA_W  write data
- rd_data_flat_i  input  N_REGS*DATA_W  current contents of all slots; slot k occupies bits [k*DATA_W +: DATA_W]
- err_clr_i  input  1  clears err_sticky_o
- wr_strb_o  output  N_REGS  one-hot write strobe, one cycle
- wr_data_o  output  DATA_W  registered write data, valid while any wr_strb_o bit is high
- rd_strb_o  output  N_REGS  one-hot read strobe, one cycle; used e.g. to pop the RX FIFO
- rd_data_o  output  DATA_W  registered read data
- rd_valid_o  output  1  rd_data_o valid, one cycle
- err_o  output  1  one-cycle pulse on a bad request
- err_sticky_o  output  1  latched error flag

Behaviour:
- Reset: asynchronous and active-high. While rst_i is high, all outputs and internal registers are 0, including the previous-cycle copies wr_q and rd_q.
- Request detection: write accepted at a rising edge when wr_i=1 and wr_q=0. Read accepted when rd_i=1 and rd_q=0. wr_q and rd_q sample wr_i and rd_i every cycle.
  - Holding a request high produces exactly one access.
  - A request already high at reset release produces one access on the first clock edge after release.
- Write path, latency 1:
  - On an accepted write at edge n with addr_i < N_REGS, during cycle n+1: wr_strb_o[addr_i]=1 and all other bits 0; wr_data_o = data_i sampled at edge n.
  - wr_data_o holds its value until the next accepted write.
  - wr_strb_o returns to 0 after one cycle.
- Read path, latency 1:
  - On an accepted read at edge n with addr_i < N_REGS, during cycle n+1: rd_data_o = slot addr_i of rd_data_flat_i sampled at edge n; rd_valid_o=1; rd_strb_o[addr_i]=1.
  - rd_data_o holds its value until the next read.
- Out-of-range address (addr_i >= N_REGS):
  - Write: no wr_strb_o bit asserted; wr_data_o unchanged; err_o pulses.
  - Read: rd_valid_o pulses with rd_data_o = 0; no rd_strb_o bit asserted; err_o pulses.
- Write and read accepted in the same cycle: the write wins. The write executes normally, the read is dropped (no rd_valid_o, no rd_strb_o) and err_o pulses.
- err_sticky_o:
  - Set on any err_o pulse; cleared the cycle after err_clr_i=1.
  - Set and clear in the same cycle: set wins.
- Strobes are always one-hot or all-zero; never more than one bit high.
- Reset asserted mid-access: pending strobes are cleared immediately; no strobe is issued after release unless a new edge is detected.

Test Plan:
- N_REGS=4, DATA_W=32. Reset, then wr_i rises with addr=2, data=0xDEADBEEF and is held 5 cycles -> wr_strb_o=4'b0100 for exactly one cycle, at the cycle after acceptance; wr_data_o=0xDEADBEEF; no further strobes.
- rd_data_flat_i slots = {0x33,0x22,0x11,0x00}; rd_i pulses with addr=1 -> one cycle later rd_data_o=0x11, rd_valid_o=1, rd_strb_o=4'b0010, each for one cycle.
- N_REGS=3, ADDR_W=2; write to addr=3 -> no wr_strb_o; err_o pulses once; err_sticky_o=1. A read at addr=3 -> rd_valid_o=1 with rd_data_o=0 and err_o pulses. Asserting err_clr_i -> err_sticky_o=0 the next cycle.
- wr_i and rd_i rise in the same cycle with addr=0 -> wr_strb_o=0001; rd_valid_o stays 0; rd_strb_o stays 0; err_o pulses.
- wr_i held high across reset deassertion -> exactly one wr_strb_o pulse on the first edge after release. Asserting rst_i in the cycle a strobe is high -> all outputs 0 immediately.
- Back-to-back toggling of wr_i (1,0,1,0) at addrs 0 then 1 -> two strobes, 0001 then 0010, spaced two cycles apart; wr_data_o updates each time.
